// File: rtl/coin_pkg.sv
// coin_pkg: shared types and constants for the coin spawner slice.
//   spawn_state_t     : controller FSM states
//   LFSR_TAPS         : feedback tap mask for x^8+x^6+x^5+x^4+1 (state bits 7,5,4,3)
//   LFSR_SEED_DEFAULT : default non-zero LFSR load value
//   BLOCK_W / SCORE_W : start_block and score widths
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SPAWN
    } spawn_state_t;

    localparam logic [7:0] LFSR_TAPS         = 8'b1011_1000;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

    localparam int unsigned BLOCK_W = 2;
    localparam int unsigned SCORE_W = 8;

endpackage

// File: rtl/coin_spawner_if.sv
// coin_spawner_if: bundle between game control / coin instances and the spawner.
//   frame_clk, game_run, Shift, coin_taken : driven by the game side (master)
//   start, start_block, score,
//   active_count, spawn_dropped            : driven by the spawner (slave)
interface coin_spawner_if import coin_pkg::*; #(
    parameter int unsigned NUM_COINS = 4
);

    localparam int unsigned CNT_W = $clog2(NUM_COINS + 1);

    logic                 frame_clk;
    logic                 game_run;
    logic                 Shift;
    logic [NUM_COINS-1:0] coin_taken;
    logic [NUM_COINS-1:0] start;
    logic [BLOCK_W-1:0]   start_block;
    logic [SCORE_W-1:0]   score;
    logic [CNT_W-1:0]     active_count;
    logic                 spawn_dropped;

    modport master (
        output frame_clk, game_run, Shift, coin_taken,
        input  start, start_block, score, active_count, spawn_dropped
    );

    modport slave (
        input  frame_clk, game_run, Shift, coin_taken,
        output start, start_block, score, active_count, spawn_dropped
    );

endinterface

// File: rtl/coin_spawner_lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR, shifting left, taps from coin_pkg::LFSR_TAPS.
//   clk, rst_n : clock, asynchronous active-low reset (state <= SEED)
//   load       : reload SEED (has priority over step)
//   step       : advance one position
//   state      : current 8-bit state
module lfsr8 import coin_pkg::*; #(
    parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [7:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= SEED;
        end else if (step) begin
            state <= {state[6:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/coin_spawner.sv
// coin_spawner: schedules the coin slot pool.
//   Clk, Reset_n : system clock, asynchronous active-low reset
//   bus (slave)  : frame_clk / game_run / Shift / coin_taken in;
//                  start (one-hot pulse), start_block, score (saturating),
//                  active_count (popcount of busy), spawn_dropped out
module coin_spawner import coin_pkg::*; #(
    parameter int unsigned NUM_COINS   = 4,
    parameter int unsigned SPAWN_GAP   = 3,
    parameter int unsigned LIFE_SHIFTS = 10,
    parameter logic [7:0]  LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input logic           Clk,
    input logic           Reset_n,
    coin_spawner_if.slave bus
);

    localparam int unsigned CNT_W     = $clog2(NUM_COINS + 1);
    localparam logic [3:0]  GAP_LAST  = 4'(SPAWN_GAP - 1);
    localparam logic [3:0]  LIFE_LAST = 4'(LIFE_SHIFTS - 1);

    spawn_state_t              state, state_next;
    logic                      frame_d, fe_q, se;
    logic [3:0]                gap_cnt;
    logic [NUM_COINS-1:0]      busy, busy_next, sel;
    logic                      free_found;
    logic [NUM_COINS-1:0][3:0] life_cnt, life_next;
    logic [SCORE_W-1:0]        score_q;
    logic [SCORE_W:0]          score_sum;
    logic [CNT_W-1:0]          active_q, active_next;
    logic [BLOCK_W-1:0]        blk_q;
    logic [7:0]                lfsr;
    logic                      run_entry, lfsr_load, lfsr_step;
    logic [NUM_COINS-1:0]      start;
    logic [BLOCK_W-1:0]        start_block;
    logic                      spawn_dropped;

    // Scroll event: registered rising edge of frame_clk qualified by Shift.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_d <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            frame_d <= bus.frame_clk;
            fe_q    <= bus.frame_clk & ~frame_d;
        end
    end

    assign se = fe_q & bus.Shift;

    // FSM: state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.game_run) state_next = RUN;
            RUN: begin
                if (!bus.game_run)                  state_next = IDLE;
                else if (se && gap_cnt == GAP_LAST) state_next = SPAWN;
            end
            SPAWN:   state_next = bus.game_run ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lowest-index free slot, judged on the busy vector from the previous cycle.
    always_comb begin
        sel        = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (!free_found && !busy[i]) begin
                sel[i]     = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    // FSM: outputs
    always_comb begin
        start         = '0;
        start_block   = blk_q;
        spawn_dropped = 1'b0;
        lfsr_step     = 1'b0;
        run_entry     = (state == IDLE) && bus.game_run;
        if (state == SPAWN) begin
            if (free_found) begin
                start       = sel;
                start_block = lfsr[BLOCK_W-1:0];
                lfsr_step   = 1'b1;
            end else begin
                spawn_dropped = 1'b1;
            end
        end
        // An all-zero state is unreachable; reloading on it recovers from upsets.
        lfsr_load = run_entry || (lfsr == '0);
    end

    // Slot occupancy, lifetime, score and active count.
    // Expiry and take both only clear busy, so a slot hit by both frees once;
    // the score term looks at the take alone.
    always_comb begin
        busy_next   = busy;
        life_next   = life_cnt;
        score_sum   = {1'b0, score_q};
        active_next = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (se && busy[i]) begin
                if (life_cnt[i] == LIFE_LAST) busy_next[i] = 1'b0;
                else                          life_next[i] = life_cnt[i] + 4'd1;
            end
            if (bus.coin_taken[i] && busy[i]) begin
                busy_next[i] = 1'b0;
                score_sum    = score_sum + 9'd1;
            end
            if (start[i]) begin
                busy_next[i] = 1'b1;
                life_next[i] = '0;
            end
        end
        if (state_next == IDLE) busy_next = '0;
        for (int unsigned i = 0; i < NUM_COINS; i++) begin
            if (busy_next[i]) active_next = active_next + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            gap_cnt  <= '0;
            busy     <= '0;
            life_cnt <= '0;
            score_q  <= '0;
            active_q <= '0;
            blk_q    <= '0;
        end else begin
            if (state == IDLE) begin
                gap_cnt <= '0;
            end else if (state == RUN && se) begin
                gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 4'd1;
            end
            busy     <= busy_next;
            life_cnt <= life_next;
            active_q <= active_next;
            if (run_entry) score_q <= '0;
            else           score_q <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            if (lfsr_step) blk_q <= lfsr[BLOCK_W-1:0];
        end
    end

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (Clk),
        .rst_n (Reset_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .state (lfsr)
    );

    assign bus.start         = start;
    assign bus.start_block   = start_block;
    assign bus.spawn_dropped = spawn_dropped;
    assign bus.score         = score_q;
    assign bus.active_count  = active_q;

endmodule

// File: tb/tb_coin_spawner.sv
// tb_coin_spawner: directed bench for coin_spawner.
// dut_a uses default parameters; dut_b shares the same stimulus but has
// LIFE_SHIFTS = 13 so that all four slots are still busy at a spawn attempt.
// LFSR sequence from seed A5: A5 -> 4A -> 95 -> 2A -> 54 -> A9.
module tb_coin_spawner;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       frame_clk;
    logic       game_run;
    logic       Shift;
    logic [3:0] coin_taken;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    coin_spawner_if #(.NUM_COINS(4)) if_a ();
    coin_spawner_if #(.NUM_COINS(4)) if_b ();

    assign if_a.frame_clk  = frame_clk;
    assign if_a.game_run   = game_run;
    assign if_a.Shift      = Shift;
    assign if_a.coin_taken = coin_taken;
    assign if_b.frame_clk  = frame_clk;
    assign if_b.game_run   = game_run;
    assign if_b.Shift      = Shift;
    assign if_b.coin_taken = coin_taken;

    coin_spawner #(
        .NUM_COINS   (4),
        .SPAWN_GAP   (3),
        .LIFE_SHIFTS (10),
        .LFSR_SEED   (8'hA5)
    ) dut_a (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (if_a)
    );

    coin_spawner #(
        .NUM_COINS   (4),
        .SPAWN_GAP   (3),
        .LIFE_SHIFTS (13),
        .LFSR_SEED   (8'hA5)
    ) dut_b (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (if_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // One frame tick; returns just after the edge that consumed the scroll event.
    task automatic frame_pulse();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame_pulse();
    endtask

    task automatic take(input logic [3:0] mask);
        coin_taken = mask;
        tick();
        coin_taken = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset_n    = 1'b0;
        frame_clk  = 1'b0;
        game_run   = 1'b0;
        Shift      = 1'b0;
        coin_taken = '0;
        tick();
        tick();
        check("rst_start",   32'(if_a.start),         32'h0);
        check("rst_block",   32'(if_a.start_block),   32'h0);
        check("rst_score",   32'(if_a.score),         32'h0);
        check("rst_active",  32'(if_a.active_count),  32'h0);
        check("rst_dropped", 32'(if_a.spawn_dropped), 32'h0);

        Reset_n = 1'b1;
        tick();
        game_run = 1'b1;
        Shift    = 1'b1;
        tick();

        // se1..se3: first spawn into slot 0
        frames(2);
        check("no_early_start", 32'(if_a.start), 32'h0);
        frame_pulse();
        check("spawn0_start", 32'(if_a.start),       32'h1);
        check("spawn0_block", 32'(if_a.start_block), 32'h1);
        check("spawn0_b",     32'(if_b.start),       32'h1);
        tick();
        check("spawn0_pulse1", 32'(if_a.start),        32'h0);
        check("spawn0_active", 32'(if_a.active_count), 32'h1);
        check("spawn0_hold",   32'(if_a.start_block),  32'h1);

        // se6, se9, se12 fill slots 1..3
        frames(3);
        check("spawn1_start", 32'(if_a.start),       32'h2);
        check("spawn1_block", 32'(if_a.start_block), 32'h2);
        tick();
        check("spawn1_active", 32'(if_a.active_count), 32'h2);
        frames(3);
        check("spawn2_start", 32'(if_a.start),       32'h4);
        check("spawn2_block", 32'(if_a.start_block), 32'h1);
        tick();
        frames(3);
        check("spawn3_start",   32'(if_a.start),       32'h8);
        check("spawn3_block",   32'(if_a.start_block), 32'h2);
        check("spawn3_b_start", 32'(if_b.start),       32'h8);
        tick();
        check("full_active_a", 32'(if_a.active_count), 32'h4);
        check("full_active_b", 32'(if_b.active_count), 32'h4);

        // se13: slot 0 of dut_a expires on its 10th scroll event
        frame_pulse();
        check("expire_a", 32'(if_a.active_count), 32'h3);
        check("alive_b",  32'(if_b.active_count), 32'h4);

        // se15: dut_a reuses slot 0, dut_b has no free slot
        frames(2);
        check("respawn_a_start", 32'(if_a.start),         32'h1);
        check("respawn_a_block", 32'(if_a.start_block),   32'h0);
        check("drop_b_start",    32'(if_b.start),         32'h0);
        check("drop_b_pulse",    32'(if_b.spawn_dropped), 32'h1);
        check("drop_a_none",     32'(if_a.spawn_dropped), 32'h0);
        tick();
        check("drop_b_once", 32'(if_b.spawn_dropped), 32'h0);
        check("drop_b_full", 32'(if_b.active_count),  32'h4);

        // se16: dut_a slot 1 and dut_b slot 0 expire
        frame_pulse();
        check("expire16_a", 32'(if_a.active_count), 32'h3);
        check("expire16_b", 32'(if_b.active_count), 32'h3);

        // se18: LFSR of dut_b did not advance on the dropped attempt
        frames(2);
        check("spawn18_a_start", 32'(if_a.start),       32'h2);
        check("spawn18_a_block", 32'(if_a.start_block), 32'h1);
        check("spawn18_b_start", 32'(if_b.start),       32'h1);
        check("spawn18_b_block", 32'(if_b.start_block), 32'h0);
        tick();
        check("spawn18_a_active", 32'(if_a.active_count), 32'h4);

        // Taken handling
        take(4'b0001);
        check("take_score",  32'(if_a.score),        32'h1);
        check("take_active", 32'(if_a.active_count), 32'h3);
        check("take_b",      32'(if_b.score),        32'h1);
        take(4'b0001);
        check("take_free_score",  32'(if_a.score),        32'h1);
        check("take_free_active", 32'(if_a.active_count), 32'h3);
        take(4'b0110);
        check("take2_score",  32'(if_a.score),        32'h3);
        check("take2_active", 32'(if_a.active_count), 32'h1);

        // game_run low: idle, busy cleared, score held until the next run
        game_run = 1'b0;
        tick();
        check("stop_active", 32'(if_a.active_count), 32'h0);
        check("stop_score",  32'(if_a.score),        32'h3);
        tick();
        check("idle_score", 32'(if_a.score), 32'h3);
        game_run = 1'b1;
        tick();
        check("rerun_score", 32'(if_a.score), 32'h0);

        // Bring score to 254 one coin at a time
        for (int i = 0; i < 254; i++) begin
            frames(3);
            tick();
            take(4'b0001);
        end
        check("score254_a", 32'(if_a.score), 32'd254);
        check("score254_b", 32'(if_b.score), 32'd254);

        frames(3);
        tick();
        frames(3);
        check("two_busy_start", 32'(if_a.start), 32'h2);
        tick();
        check("two_busy_active", 32'(if_a.active_count), 32'h2);
        take(4'b0011);
        check("sat_a",        32'(if_a.score),        32'd255);
        check("sat_b",        32'(if_b.score),        32'd255);
        check("sat_active",   32'(if_a.active_count), 32'h0);
        frames(3);
        tick();
        take(4'b0001);
        check("sat_hold", 32'(if_a.score), 32'd255);

        // game_run dropped during SPAWN: pulse still emitted, then idle
        frames(3);
        check("spawn_then_stop", 32'(if_a.start), 32'h1);
        game_run = 1'b0;
        tick();
        check("stop2_start",  32'(if_a.start),        32'h0);
        check("stop2_active", 32'(if_a.active_count), 32'h0);
        check("stop2_score",  32'(if_a.score),        32'd255);
        game_run = 1'b1;
        tick();
        check("rerun2_score", 32'(if_a.score), 32'h0);

        // LFSR reloads to seed on run entry
        frames(3);
        check("reload_block", 32'(if_a.start_block), 32'h1);
        tick();
        take(4'b0001);
        check("reload_score", 32'(if_a.score), 32'h1);
        frames(3);
        check("pre_rst_start", 32'(if_a.start),       32'h1);
        check("pre_rst_block", 32'(if_a.start_block), 32'h2);

        // Asynchronous reset in the middle of a start pulse
        Reset_n = 1'b0;
        #1;
        check("mid_rst_start",   32'(if_a.start),         32'h0);
        check("mid_rst_block",   32'(if_a.start_block),   32'h0);
        check("mid_rst_score",   32'(if_a.score),         32'h0);
        check("mid_rst_active",  32'(if_a.active_count),  32'h0);
        check("mid_rst_dropped", 32'(if_a.spawn_dropped), 32'h0);
        check("mid_rst_b",       32'(if_b.start),         32'h0);
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_start", 32'(if_a.start), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_spawner.md
# coin_spawner

Controller that schedules the pool of coin instances in the playfield. It counts scroll events, picks a free coin slot at a fixed spawn interval, and issues that slot's one-cycle start pulse together with a pseudo-random start block. It tracks slot occupancy from each slot's taken pulse and a lifetime shift count, and keeps the saturating coin score for the HUD. It sits between the top-level game control and the NUM_COINS coin instances; it shares one start_block bus across all slots.

## Interface
- NUM_COINS, default 4: number of coin slots driven (1..8).
- SPAWN_GAP, default 3: scroll events between spawn attempts (1..15).
- LIFE_SHIFTS, default 10: scroll events after which an untaken coin is off-screen and its slot frees (1..15).
- LFSR_SEED, default 8'hA5: non-zero LFSR load value.
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_clk  in  1  frame tick; only its rising edge is used.
- game_run  in  1  level; high while a level is being played.
- Shift  in  1  scroll request, sampled on a frame edge.
- coin_taken  in  NUM_COINS  per-slot one-cycle taken pulse from each coin instance.
- start  out  NUM_COINS  one-hot, one-cycle spawn pulse to the selected slot.
- start_block  out  2  block row for the spawned coin; valid in the start cycle and held afterwards.
- score  out  8  coins collected this run; saturates at 255.
- active_count  out  $clog2(NUM_COINS+1)  number of busy slots.
- spawn_dropped  out  1  one-cycle pulse when a spawn attempt finds no free slot.

## Operation
- Frame edge detect: register frame_clk into frame_d. fe = frame_clk & ~frame_d, registered. A scroll event is se = fe_q & Shift.
- State machine (coin_pkg::spawn_state_t):
  - IDLE: all slots free, counters cleared. Transition to RUN when game_run is high. Entry into RUN clears score to 0 and reloads the LFSR with LFSR_SEED.
  - RUN: each se increments gap_cnt. When gap_cnt reaches SPAWN_GAP-1 on an se, go to SPAWN and clear gap_cnt.
  - SPAWN: lasts exactly 1 cycle, then returns to RUN.
    - Select the lowest-index slot whose busy bit is clear.
    - If a slot is found: assert start[i], drive start_block = lfsr[1:0], set busy[i], clear life_cnt[i], and step the LFSR once.
    - If no slot is free: start = 0, pulse spawn_dropped, leave the LFSR unchanged.
  - Any state except IDLE: game_run low forces IDLE on the next cycle. Busy bits clear; score holds its value.
- Slot lifetime:
  - On each se, every busy slot increments its 4-bit life_cnt.
  - A busy slot with life_cnt == LIFE_SHIFTS-1 at an se frees on that se.
- Taken handling:
  - coin_taken[i] with busy[i] set clears busy[i] and adds 1 to score.
  - coin_taken[i] on a non-busy slot is ignored.
  - Several slots taken in the same cycle add their popcount to score, saturating at 255.
- Simultaneous events:
  - Slot selection uses the busy vector registered before the current cycle. A slot freed in the SPAWN cycle becomes eligible on the next spawn.
  - Taken and lifetime expiry on the same slot in the same cycle free the slot once; score still counts the taken pulse.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifting left. It never reaches zero.
- active_count equals popcount(busy), registered.

## Timing
- Reset (Reset_n low) values:
  - Outputs: start = 0, start_block = 2'b00, score = 0, active_count = 0, spawn_dropped = 0.
  - Internal: state = IDLE, busy = 0, lfsr = LFSR_SEED.
- Reset asserted mid-operation returns every register to its reset value at once; no start pulse is emitted after the deassertion edge.
- Latency:
  - frame_clk rising to the se cycle: 2 Clk cycles.
  - se that completes the gap to the start pulse: 1 cycle.
  - coin_taken to score/active_count update: 1 cycle.
- start is never asserted on more than one bit. There are at least 2 cycles between any two start pulses.
- game_run falling edge to IDLE: 1 cycle. A SPAWN in progress completes its pulse first.

## Structure
- Package coin_pkg holds:
  - spawn_state_t enum {IDLE, RUN, SPAWN}.
  - LFSR tap constant and default LFSR_SEED.
  - BLOCK_W = 2, SCORE_W = 8.
- Sub-module lfsr8 provides load, step and an 8-bit state output. All remaining logic stays in coin_spawner.

## Test plan
- Reset, then game_run = 1 with Shift held high over 3 frame ticks: start = 4'b0001, start_block = 2'b01 (seed A5), active_count = 1 one cycle later.
- Coin in slot 0 alive, coin_taken = 4'b0001 for one cycle: busy[0] clears, score 0 -> 1, active_count 1 -> 0.
- No takes over 10 further scroll events after a spawn: slot 0 frees on the 10th se. Spawns occur on every 3rd se, filling slots 1, 2, 3 in order.
- All 4 slots busy at a spawn attempt: start stays 0, spawn_dropped pulses once, LFSR value unchanged at the next successful spawn.
- score at 254 with coin_taken = 4'b0011 on two busy slots: score = 255, then holds 255 on further takes.
- Reset_n pulled low mid-RUN: all outputs are 0 in the same cycle. game_run dropped instead: state returns to IDLE, busy clears, score held until game_run rises again, then clears.
